// File: rtl/if_fetch_queue.sv
// IF-stage fetch engine: issues PCs to instruction memory, keeps up to DEPTH
// fetches in an in-order ring and hands {pc, inst} to ID. After a jump flush,
// responses still owed for killed requests are counted and silently dropped.
module if_fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  ce_i,
    input  logic                  flush_jump_i,
    input  logic                  id_stall_i,
    output logic                  pc_stall_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  inst_valid_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);

    // Pointers carry one wrap bit so full (used == DEPTH) differs from empty.
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] disc_cnt_q, disc_cnt_d;
    logic [DEPTH-1:0] filled_q, filled_d;

    logic [ADDR_WIDTH-1:0] slot_pc_q   [DEPTH];
    logic [DATA_WIDTH-1:0] slot_inst_q [DEPTH];

    logic [PTR_W-1:0] used;
    logic [PTR_W-1:0] inflight;
    logic [PTR_W:0]   occupancy;
    logic [IDX_W-1:0] rd_idx, fill_idx, wr_idx;
    logic             req, alloc, discard, fill, pop, retire;

    assign used      = wr_ptr_q - rd_ptr_q;
    assign inflight  = wr_ptr_q - fill_ptr_q;
    assign occupancy = {1'b0, used} + {1'b0, disc_cnt_q};
    assign rd_idx    = rd_ptr_q[IDX_W-1:0];
    assign fill_idx  = fill_ptr_q[IDX_W-1:0];
    assign wr_idx    = wr_ptr_q[IDX_W-1:0];

    // Killed requests still reserve a slot's worth of budget until their
    // response comes back, so a late response can never overrun the ring.
    assign req     = ce_i & ~flush_jump_i & (occupancy < DEPTH_C);
    assign alloc   = req & mem_gnt_i;
    assign discard = mem_rvalid_i & (disc_cnt_q != '0);
    assign fill    = mem_rvalid_i & ~flush_jump_i & (disc_cnt_q == '0) & (inflight != '0);
    // A response on a flush cycle retires one outstanding request, killed or not.
    assign retire  = mem_rvalid_i & ((disc_cnt_q != '0) | (inflight != '0));

    assign inst_valid_o = filled_q[rd_idx] & (used != '0);
    assign inst_o       = slot_inst_q[rd_idx];
    assign inst_pc_o    = slot_pc_q[rd_idx];
    assign pop          = inst_valid_o & ~id_stall_i & ~flush_jump_i;

    assign mem_req_o  = req & ~rst_i;
    assign mem_addr_o = rst_i ? '0 : pc_i;
    assign pc_stall_o = rst_i ? ce_i : ~alloc;

    // Next-state for pointers, discard counter and slot filled bits.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        fill_ptr_d = fill_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        disc_cnt_d = disc_cnt_q;
        filled_d   = filled_q;
        if (flush_jump_i) begin
            rd_ptr_d   = wr_ptr_q;
            fill_ptr_d = wr_ptr_q;
            filled_d   = '0;
            disc_cnt_d = disc_cnt_q + inflight - {{(PTR_W-1){1'b0}}, retire};
        end else begin
            if (discard) begin
                disc_cnt_d = disc_cnt_q - PTR_ONE;
            end
            if (fill) begin
                fill_ptr_d         = fill_ptr_q + PTR_ONE;
                filled_d[fill_idx] = 1'b1;
            end
            if (alloc) begin
                wr_ptr_d         = wr_ptr_q + PTR_ONE;
                filled_d[wr_idx] = 1'b0;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // State registers and slot payload storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            fill_ptr_q <= '0;
            wr_ptr_q   <= '0;
            disc_cnt_q <= '0;
            filled_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_q[i]   <= '0;
                slot_inst_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            disc_cnt_q <= disc_cnt_d;
            filled_q   <= filled_d;
            if (alloc) begin
                slot_pc_q[wr_idx] <= pc_i;
            end
            if (fill) begin
                slot_inst_q[fill_idx] <= mem_rdata_i;
            end
        end
    end

    // A response with nothing outstanding is a bus protocol error; it is ignored.
    a_rsp_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> ((inflight != '0) || (disc_cnt_q != '0)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: a queue-based reference model of the fetch stream
// plus an in-order memory responder with configurable grant/response behaviour.
`timescale 1ns/1ps
module tb_if_fetch_queue;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] pc_i = '0;
    logic          ce_i = 1'b0;
    logic          flush_jump_i = 1'b0;
    logic          id_stall_i = 1'b0;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          pc_stall_o, mem_req_o, inst_valid_o;
    logic [AW-1:0] mem_addr_o, inst_pc_o;
    logic [DW-1:0] inst_o;

    if_fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .ce_i(ce_i),
        .flush_jump_i(flush_jump_i), .id_stall_i(id_stall_i),
        .pc_stall_o(pc_stall_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: fetches in program order still headed for ID, plus
    // the number of killed fetches whose responses are still owed.
    typedef struct { logic [AW-1:0] pc; bit filled; } ent_t;
    typedef struct { logic [AW-1:0] pc; int due; } mreq_t;
    ent_t          live[$];
    int            owed;
    mreq_t         mem_q[$];
    logic [AW-1:0] deliv[$];
    int            deliv_cyc[$];
    int            n_grant, n_pop;

    int gnt_pct = 100, rv_pct = 100, dly_min = 1, dly_max = 1;

    function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic reset_model();
        live.delete(); mem_q.delete(); deliv.delete(); deliv_cyc.delete();
        owed = 0; n_grant = 0; n_pop = 0; pc_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; ce_i = 1'b0; flush_jump_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; id_stall_i = 1'b0;
        reset_model();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, update on the edge.
    task automatic step(input bit flush, input logic [AW-1:0] target);
        bit exp_req, exp_valid, acc, popd, rv, stall_now;
        logic [AW-1:0] cur_pc;
        int unfilled;
        flush_jump_i = flush;
        mem_gnt_i    = ($urandom_range(99) < gnt_pct);
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < rv_pct);
        mem_rvalid_i = rv;
        mem_rdata_i  = rv ? inst_of(mem_q[0].pc) : DW'($urandom);
        #1;
        cur_pc    = pc_i;
        stall_now = id_stall_i;
        exp_valid = (live.size() > 0) && live[0].filled;
        exp_req   = ce_i && !flush && (live.size() + owed < DEPTH);
        checks++;
        if (mem_req_o !== exp_req) begin
            errors++; $display("FAIL mem_req cyc %0d: got %b want %b", cyc, mem_req_o, exp_req);
        end
        checks++;
        if (pc_stall_o !== !(exp_req && mem_gnt_i)) begin
            errors++; $display("FAIL pc_stall cyc %0d: got %b want %b", cyc, pc_stall_o, !(exp_req && mem_gnt_i));
        end
        checks++;
        if (inst_valid_o !== exp_valid) begin
            errors++; $display("FAIL inst_valid cyc %0d: got %b want %b", cyc, inst_valid_o, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (inst_pc_o !== live[0].pc || inst_o !== inst_of(live[0].pc)) begin
                errors++;
                $display("FAIL head cyc %0d: got pc %h inst %h want pc %h inst %h",
                         cyc, inst_pc_o, inst_o, live[0].pc, inst_of(live[0].pc));
            end
        end
        if (exp_req) begin
            checks++;
            if (mem_addr_o !== cur_pc) begin
                errors++; $display("FAIL mem_addr cyc %0d: got %h want %h", cyc, mem_addr_o, cur_pc);
            end
        end
        acc  = exp_req && mem_gnt_i;
        popd = exp_valid && !stall_now && !flush;
        @(posedge clk_i);
        if (rv) begin
            void'(mem_q.pop_front());
            if (owed > 0) owed--;
            else begin
                for (int i = 0; i < live.size(); i++) begin
                    if (!live[i].filled) begin live[i].filled = 1'b1; break; end
                end
            end
        end
        if (flush) begin
            unfilled = 0;
            foreach (live[i]) if (!live[i].filled) unfilled++;
            owed += unfilled;
            live.delete();
        end else begin
            if (popd) begin
                deliv.push_back(live[0].pc); deliv_cyc.push_back(cyc);
                void'(live.pop_front()); n_pop++;
            end
            if (acc) begin
                ent_t e;
                e.pc = cur_pc; e.filled = 1'b0;
                live.push_back(e);
            end
        end
        if (acc) begin
            mreq_t m;
            m.pc = cur_pc; m.due = cyc + $urandom_range(dly_max, dly_min);
            mem_q.push_back(m); n_grant++;
        end
        cyc++;
        @(negedge clk_i);
        if (flush) pc_i = target;
        else if (acc) pc_i = cur_pc + 32'd4;
    endtask

    task automatic test_reset();
        reset_model();
        rst_i = 1'b1; ce_i = 1'b1;
        @(negedge clk_i);
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_stall_o !== 1'b1) begin
            errors++; $display("FAIL reset_hold: req %b valid %b stall %b want 0 0 1", mem_req_o, inst_valid_o, pc_stall_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        checks++;
        if (mem_addr_o !== 32'h0 || mem_req_o !== 1'b1) begin
            errors++; $display("FAIL reset_first_addr: addr %h req %b want 0 1", mem_addr_o, mem_req_o);
        end
        @(negedge clk_i);
        gnt_pct = 100; rv_pct = 100; dly_min = 1; dly_max = 1;
        reset_model();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        #2;
        rst_i = 1'b1; mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== '0 ||
            inst_pc_o !== '0 || mem_addr_o !== '0 || pc_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: req %b valid %b inst %h pc %h addr %h stall %b want 0 0 0 0 0 1",
                     mem_req_o, inst_valid_o, inst_o, inst_pc_o, mem_addr_o, pc_stall_o);
        end
        ce_i = 1'b0;
        #1;
        checks++;
        if (pc_stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_stall_ce0: got %b want 0", pc_stall_o);
        end
        reset_model();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_streaming();
        int c0;
        do_reset();
        gnt_pct = 100; rv_pct = 100; dly_min = 1; dly_max = 1;
        ce_i = 1'b1; c0 = cyc;
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        ce_i = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, '0);
        checks++;
        if (deliv.size() != 3) begin
            errors++; $display("FAIL stream_count: got %0d want 3", deliv.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (deliv[i] !== AW'(4 * i) || deliv_cyc[i] != c0 + 2 + i) begin
                    errors++;
                    $display("FAIL stream_%0d: got pc %h at cycle %0d want pc %h at cycle %0d",
                             i, deliv[i], deliv_cyc[i] - c0, 4 * i, 2 + i);
                end
            end
        end
    endtask

    task automatic test_full();
        int g0, p0;
        do_reset();
        gnt_pct = 100; rv_pct = 100; dly_min = 1; dly_max = 1;
        ce_i = 1'b1; id_stall_i = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, '0);
        #1;
        checks++;
        if (n_grant != DEPTH || mem_req_o !== 1'b0 || pc_stall_o !== 1'b1) begin
            errors++; $display("FAIL full: grants %0d req %b stall %b want %0d 0 1", n_grant, mem_req_o, pc_stall_o, DEPTH);
        end
        id_stall_i = 1'b0;
        g0 = n_grant; p0 = n_pop;
        for (int i = 0; i < 6; i++) step(1'b0, '0);
        checks++;
        if (n_pop - p0 != 6 || n_grant - g0 != 5) begin
            errors++; $display("FAIL full_release: pops %0d grants %0d want 6 5", n_pop - p0, n_grant - g0);
        end
    endtask

    task automatic test_flush_inflight();
        do_reset();
        gnt_pct = 100; rv_pct = 100; dly_min = 4; dly_max = 4;
        ce_i = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        step(1'b1, 32'h100);
        step(1'b0, '0);
        ce_i = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b0, '0);
        checks++;
        if (deliv.size() != 1 || deliv[0] !== 32'h100) begin
            errors++; $display("FAIL flush_first_pc: got %0d deliveries first %h want 1 of 00000100",
                               deliv.size(), deliv.size() > 0 ? deliv[0] : 32'hx);
        end
        id_stall_i = 1'b1; ce_i = 1'b1; n_grant = 0;
        for (int i = 0; i < 10; i++) step(1'b0, '0);
        checks++;
        if (n_grant != DEPTH) begin
            errors++; $display("FAIL flush_disc_drained: grants %0d want %0d", n_grant, DEPTH);
        end
    endtask

    task automatic test_flush_coincident();
        do_reset();
        gnt_pct = 100; rv_pct = 100; dly_min = 1; dly_max = 1;
        ce_i = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b1, 32'h200);
        #1;
        checks++;
        if (inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL coinc_valid: got %b want 0", inst_valid_o);
        end
        id_stall_i = 1'b1; n_grant = 0;
        for (int i = 0; i < 10; i++) step(1'b0, '0);
        checks++;
        if (n_grant != DEPTH || deliv.size() != 0) begin
            errors++; $display("FAIL coinc_disc: grants %0d deliveries %0d want %0d 0", n_grant, deliv.size(), DEPTH);
        end
    endtask

    task automatic test_wrap();
        int budget;
        bit seq_ok;
        do_reset();
        gnt_pct = 60; rv_pct = 70; dly_min = 1; dly_max = 3;
        ce_i = 1'b1;
        budget = 0;
        while (deliv.size() < 3 * DEPTH && budget < 500) begin
            id_stall_i = ($urandom_range(99) < 30);
            step(1'b0, '0);
            budget++;
        end
        checks++;
        if (deliv.size() < 3 * DEPTH) begin
            errors++; $display("FAIL wrap_timeout: got %0d deliveries want %0d", deliv.size(), 3 * DEPTH);
        end
        seq_ok = 1'b1;
        foreach (deliv[i]) if (deliv[i] !== AW'(4 * i)) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin
            errors++; $display("FAIL wrap_sequence: delivered %p want 0,4,8,...", deliv);
        end
        id_stall_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_full();
        test_flush_inflight();
        test_flush_coincident();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
